// File: rtl/gray_monitor.sv
// Downstream checker for a 3-bit Gray step counter.
// Registers the binary equivalent of the incoming code every cycle.
// Counts legal forward steps and wraps.
// Latches a sticky fault on an illegal transition or an Overflow inconsistency.
module gray_monitor #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [2:0]       Gray_In,
    input  logic             Ovf_In,
    output logic [2:0]       Bin,
    output logic             Step,
    output logic [CNT_W-1:0] WrapCnt,
    output logic             Locked,
    output logic             Fault,
    output logic [1:0]       FaultCode
);

    typedef enum logic [1:0] {
        StIdle,
        StTrack,
        StFault
    } state_e;

    localparam logic [1:0] CodeNone = 2'b00;
    localparam logic [1:0] CodeJump = 2'b01;
    localparam logic [1:0] CodeBack = 2'b10;
    localparam logic [1:0] CodeOvf  = 2'b11;

    state_e           state_q, state_d;
    logic [2:0]       bin_q, bin_d;
    logic             step_q, step_d;
    logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic             fault_q, fault_d;
    logic [1:0]       fault_code_q, fault_code_d;
    logic [2:0]       prev_q, prev_d;
    logic             prev_ovf_q, prev_ovf_d;

    logic [2:0] bin_in;
    logic [2:0] prev_bin;
    logic [2:0] delta;
    logic       wrap;
    logic       ovf_mismatch;

    // Gray-to-binary conversion of the live input and the previous code, plus step classification
    always_comb begin
        bin_in[2]   = Gray_In[2];
        bin_in[1]   = Gray_In[2] ^ Gray_In[1];
        bin_in[0]   = bin_in[1] ^ Gray_In[0];
        prev_bin[2] = prev_q[2];
        prev_bin[1] = prev_q[2] ^ prev_q[1];
        prev_bin[0] = prev_bin[1] ^ prev_q[0];
        // 3-bit subtraction wraps modulo 8 by construction
        delta        = bin_in - prev_bin;
        wrap         = (prev_q == 3'b100) && (Gray_In == 3'b000);
        // Overflow may only rise together with a wrap, never fall, and must be high on a wrap
        ovf_mismatch = (prev_ovf_q && !Ovf_In)
                     || (!prev_ovf_q && Ovf_In && !wrap)
                     || (wrap && !Ovf_In);
    end

    // Next-state logic: lock on a clean 000, then check every transition in priority order
    always_comb begin
        state_d      = state_q;
        bin_d        = bin_in;
        step_d       = 1'b0;
        wrap_cnt_d   = wrap_cnt_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        prev_d       = prev_q;
        prev_ovf_d   = prev_ovf_q;

        case (state_q)
            StIdle: begin
                if ((Gray_In == 3'b000) && !Ovf_In) begin
                    state_d    = StTrack;
                    prev_d     = 3'b000;
                    prev_ovf_d = 1'b0;
                end
            end
            StTrack: begin
                prev_d     = Gray_In;
                prev_ovf_d = Ovf_In;
                if (ovf_mismatch) begin
                    state_d      = StFault;
                    fault_d      = 1'b1;
                    fault_code_d = CodeOvf;
                end else if (delta == 3'd7) begin
                    state_d      = StFault;
                    fault_d      = 1'b1;
                    fault_code_d = CodeBack;
                end else if (delta >= 3'd2) begin
                    state_d      = StFault;
                    fault_d      = 1'b1;
                    fault_code_d = CodeJump;
                end else if (delta == 3'd1) begin
                    step_d = 1'b1;
                    if (wrap && (wrap_cnt_q != {CNT_W{1'b1}})) begin
                        wrap_cnt_d = wrap_cnt_q + 1'b1;
                    end
                end
            end
            StFault: begin
                // Frozen until Reset; only Bin keeps tracking
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-high reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= StIdle;
            bin_q        <= 3'b000;
            step_q       <= 1'b0;
            wrap_cnt_q   <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= CodeNone;
            prev_q       <= 3'b000;
            prev_ovf_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            step_q       <= step_d;
            wrap_cnt_q   <= wrap_cnt_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            prev_q       <= prev_d;
            prev_ovf_q   <= prev_ovf_d;
        end
    end

    assign Bin       = bin_q;
    assign Step      = step_q;
    assign WrapCnt   = wrap_cnt_q;
    assign Locked    = (state_q == StTrack);
    assign Fault     = fault_q;
    assign FaultCode = fault_code_q;

endmodule

// File: tb/tb_gray_monitor.sv
// Self-checking bench for gray_monitor: a directed vector table, hand-written
// saturation/reset sequences, then random stimulus against a reference model.
module tb_gray_monitor;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [2:0] Gray_In = 3'b000;
    logic       Ovf_In = 1'b0;

    logic [2:0] bin, bin_s;
    logic       step, step_s;
    logic [7:0] wrap_cnt;
    logic [1:0] wrap_cnt_s;
    logic       locked, locked_s;
    logic       fault, fault_s;
    logic [1:0] code, code_s;

    int errors = 0;
    int checks = 0;

    // Upstream Gray sequence: position -> code
    logic [2:0] gseq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    gray_monitor #(.CNT_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .Gray_In(Gray_In), .Ovf_In(Ovf_In),
        .Bin(bin), .Step(step), .WrapCnt(wrap_cnt), .Locked(locked),
        .Fault(fault), .FaultCode(code)
    );

    gray_monitor #(.CNT_W(2)) dut_sat (
        .Clk(Clk), .Reset(Reset), .Gray_In(Gray_In), .Ovf_In(Ovf_In),
        .Bin(bin_s), .Step(step_s), .WrapCnt(wrap_cnt_s), .Locked(locked_s),
        .Fault(fault_s), .FaultCode(code_s)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       r;
        logic [2:0] g;
        logic       o;
        logic [2:0] bin;
        logic       step;
        logic       lk;
        logic       f;
        logic [1:0] code;
        int         w;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    int m_mode;      // 0 idle, 1 tracking, 2 faulted
    int m_prev_pos;
    int m_prev_ovf;
    int m_wraps;
    int m_fault;
    int m_code;
    int m_step;
    int m_bin;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic [2:0] g, input logic o);
        Reset   = r;
        Gray_In = g;
        Ovf_In  = o;
        @(posedge Clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int eb, input int es, input int el,
                             input int ef, input int ec, input int ew);
        int ews;
        ews = (ew > 3) ? 3 : ew;
        chk({tag, " bin"}, int'(bin), eb);
        chk({tag, " step"}, int'(step), es);
        chk({tag, " locked"}, int'(locked), el);
        chk({tag, " fault"}, int'(fault), ef);
        chk({tag, " code"}, int'(code), ec);
        chk({tag, " wrapcnt"}, int'(wrap_cnt), (ew > 255) ? 255 : ew);
        chk({tag, " sat_wrapcnt"}, int'(wrap_cnt_s), ews);
        chk({tag, " sat_fault"}, int'(fault_s), ef);
    endtask

    function automatic int pos_of(input logic [2:0] g);
        for (int i = 0; i < 8; i++) begin
            if (gseq[i] == g) return i;
        end
        return 0;
    endfunction

    function automatic void add(input logic r, input logic [2:0] g, input logic o,
                                input logic [2:0] eb, input logic es, input logic el,
                                input logic ef, input logic [1:0] ec, input int ew);
        vec_t v;
        v.r = r; v.g = g; v.o = o; v.bin = eb; v.step = es; v.lk = el;
        v.f = ef; v.code = ec; v.w = ew;
        vecs.push_back(v);
    endfunction

    // Reference model: applies one clock edge of the spec's rules at sequence-position level
    task automatic model_edge(input logic r, input logic [2:0] g, input logic o);
        int p, d, wrapped, bad_ovf;
        if (r) begin
            m_mode = 0; m_prev_pos = 0; m_prev_ovf = 0; m_wraps = 0;
            m_fault = 0; m_code = 0; m_step = 0; m_bin = 0;
            return;
        end
        p      = pos_of(g);
        m_bin  = p;
        m_step = 0;
        if (m_mode == 0) begin
            if (p == 0 && !o) begin
                m_mode = 1; m_prev_pos = 0; m_prev_ovf = 0;
            end
        end else if (m_mode == 1) begin
            d       = (p - m_prev_pos + 8) % 8;
            wrapped = (m_prev_pos == 7 && p == 0);
            bad_ovf = (m_prev_ovf == 1 && o == 0) || (m_prev_ovf == 0 && o == 1 && !wrapped)
                    || (wrapped && o == 0);
            if (bad_ovf) begin
                m_mode = 2; m_fault = 1; m_code = 3;
            end else if (d == 7) begin
                m_mode = 2; m_fault = 1; m_code = 2;
            end else if (d >= 2) begin
                m_mode = 2; m_fault = 1; m_code = 1;
            end else if (d == 1) begin
                m_step = 1;
                if (wrapped) m_wraps++;
            end
            m_prev_pos = p;
            m_prev_ovf = int'(o);
        end
    endtask

    initial begin
        int u, uo, sel;
        logic [2:0] g;
        logic o, r;

        // Lock, full count with wrap, hold, backward step, frozen fault
        add(1, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 0, 1, 0, 0, 0);
        add(0, 3'b000, 0, 0, 0, 1, 0, 0, 0);
        add(0, 3'b001, 0, 1, 1, 1, 0, 0, 0);
        add(0, 3'b011, 0, 2, 1, 1, 0, 0, 0);
        add(0, 3'b010, 0, 3, 1, 1, 0, 0, 0);
        add(0, 3'b110, 0, 4, 1, 1, 0, 0, 0);
        add(0, 3'b111, 0, 5, 1, 1, 0, 0, 0);
        add(0, 3'b101, 0, 6, 1, 1, 0, 0, 0);
        add(0, 3'b100, 0, 7, 1, 1, 0, 0, 0);
        add(0, 3'b000, 1, 0, 1, 1, 0, 0, 1);
        add(0, 3'b001, 1, 1, 1, 1, 0, 0, 1);
        add(0, 3'b011, 1, 2, 1, 1, 0, 0, 1);
        add(0, 3'b011, 1, 2, 0, 1, 0, 0, 1);
        add(0, 3'b011, 1, 2, 0, 1, 0, 0, 1);
        add(0, 3'b011, 1, 2, 0, 1, 0, 0, 1);
        add(0, 3'b001, 1, 1, 0, 0, 1, 2, 1);
        add(0, 3'b011, 1, 2, 0, 0, 1, 2, 1);
        // Jump fault, then legal codes keep Bin tracking with fault frozen
        add(1, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 0, 1, 0, 0, 0);
        add(0, 3'b011, 0, 2, 0, 0, 1, 1, 0);
        add(0, 3'b010, 0, 3, 0, 0, 1, 1, 0);
        add(0, 3'b110, 0, 4, 0, 0, 1, 1, 0);
        add(0, 3'b111, 0, 5, 0, 0, 1, 1, 0);
        add(0, 3'b101, 0, 6, 0, 0, 1, 1, 0);
        add(0, 3'b100, 0, 7, 0, 0, 1, 1, 0);
        // Overflow rising without a wrap
        add(1, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 0, 1, 0, 0, 0);
        add(0, 3'b001, 0, 1, 1, 1, 0, 0, 0);
        add(0, 3'b011, 1, 2, 0, 0, 1, 3, 0);
        // Wrap with Overflow low
        add(1, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 0, 1, 0, 0, 0);
        for (int p = 1; p < 8; p++) add(0, gseq[p], 0, 3'(p), 1, 1, 0, 0, 0);
        add(0, 3'b000, 0, 0, 0, 0, 1, 3, 0);
        // Reset ignores Gray_In; IDLE waits for 000 with Overflow low
        add(1, 3'b101, 1, 0, 0, 0, 0, 0, 0);
        add(0, 3'b101, 1, 6, 0, 0, 0, 0, 0);
        add(0, 3'b000, 1, 0, 0, 0, 0, 0, 0);
        add(0, 3'b000, 0, 0, 0, 1, 0, 0, 0);

        @(posedge Clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].r, vecs[i].g, vecs[i].o);
            check_all($sformatf("vec%0d", i), vecs[i].bin, vecs[i].step, vecs[i].lk,
                      vecs[i].f, vecs[i].code, vecs[i].w);
        end

        // Five full wraps: the 2-bit counter saturates at 3, the 8-bit one reaches 5
        cycle(1, 3'b000, 0);
        cycle(0, 3'b000, 0);
        for (int k = 0; k < 5; k++) begin
            for (int p = 1; p < 8; p++) cycle(0, gseq[p], (k > 0) ? 1'b1 : 1'b0);
            cycle(0, 3'b000, 1);
        end
        check_all("sat", 0, 1, 1, 0, 0, 5);
        chk("sat locked_s", int'(locked_s), 1);
        cycle(0, 3'b001, 1);
        cycle(0, 3'b011, 1);
        check_all("sat_mid", 2, 1, 1, 0, 0, 5);
        // Reset mid-sequence restores everything on that edge
        cycle(1, 3'b010, 1);
        check_all("mid_reset", 0, 0, 0, 0, 0, 0);
        chk("mid_reset bin_s", int'(bin_s), 0);
        chk("mid_reset code_s", int'(code_s), 0);

        // Random stimulus against the reference model
        model_edge(1, 3'b000, 0);
        u = 0; uo = 0;
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 99));
            r = 1'b0;
            if (n == 0 || sel < 3) begin
                r = 1'b1; u = 0; uo = 0;
            end else if (sel < 58) begin
                u = (u + 1) % 8;
                if (u == 0) uo = 1;
            end else if (sel < 82) begin
                // hold
            end else if (sel < 89) begin
                u = int'($urandom_range(0, 7));
            end else if (sel < 93) begin
                uo = 1 - uo;
            end else begin
                u = 0; uo = 0;
            end
            g = gseq[u];
            o = (uo != 0);
            cycle(r, g, o);
            model_edge(r, g, o);
            check_all($sformatf("rnd%0d", n), m_bin, m_step, (m_mode == 1) ? 1 : 0,
                      m_fault, m_code, m_wraps);
            chk($sformatf("rnd%0d step_s", n), int'(step_s), m_step);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
